uart_rx_buffer_ctrl: RTL

UART_RX_BUFFER_CTRL -- requirements
Module: uart_rx_buffer_ctrl

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_fifo_mem.sv | 26 ++
 rtl/uart_rx_buffer_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and default constants for the UART receive buffer controller.
package uart_rx_pkg;

    localparam int unsigned DATA_W            = 8;
    localparam int unsigned DEF_DEPTH         = 16;
    localparam int unsigned DEF_TIMEOUT_TICKS = 640;

    // One buffered character together with the line errors seen while receiving it.
    typedef struct packed {
        logic              stop_err;
        logic              parity_err;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    localparam int unsigned ENTRY_W = $bits(rx_entry_t);

    // Flow-control state toward the remote transmitter.
    typedef enum logic {
        RTS_READY = 1'b0,
        RTS_HOLD  = 1'b1
    } rts_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for the RX FIFO: synchronous write port, asynchronous read port.
module uart_rx_fifo_mem
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  rx_entry_t                  wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output rx_entry_t                  rdata_o
);

    rx_entry_t mem_q [DEPTH];

    // Write the incoming entry; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive buffer: FWFT FIFO control, sticky overrun, idle timeout and RTS flow control.
module uart_rx_buffer_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned HIGH_WATER    = DEPTH - 2,
    parameter int unsigned LOW_WATER     = DEPTH / 2,
    parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick_i,
    input  logic                     rx_en_i,
    input  logic                     rx_valid_i,
    input  logic [DATA_W-1:0]        rx_data_i,
    input  logic                     parity_err_i,
    input  logic                     stop_bit_err_i,
    input  logic                     rd_en_i,
    input  logic                     fifo_clr_i,
    input  logic                     ovr_clr_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_parity_err_o,
    output logic                     rd_stop_err_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     overrun_o,
    output logic                     timeout_o,
    output logic                     rts_no
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HW_CNT    = CW'(HIGH_WATER);
    localparam logic [CW-1:0] LW_CNT    = CW'(LOW_WATER);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_TICKS);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ovr_q, ovr_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;
    rts_state_e    state_q, state_d;
    logic          rts_no_q;

    logic          push_c;
    logic          pop_c;
    logic          lost_c;
    logic          wr_en_c;
    rx_entry_t     wr_entry_c;
    rx_entry_t     mem_rdata_c;
    rx_entry_t     head_c;

    // Qualify push/pop requests; a push into a full FIFO is legal only alongside a pop.
    always_comb begin
        push_c  = rx_valid_i & rx_en_i & (~full_q | rd_en_i);
        pop_c   = rd_en_i & ~empty_q;
        lost_c  = rx_valid_i & rx_en_i & full_q & ~rd_en_i;
        wr_en_c = push_c & ~fifo_clr_i;

        wr_entry_c            = '0;
        wr_entry_c.stop_err   = stop_bit_err_i;
        wr_entry_c.parity_err = parity_err_i;
        wr_entry_c.data       = rx_data_i;
    end

    // Pointer and occupancy update; a flush overrides any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
    end

    // Sticky overrun: a lost push in the same cycle as a clear request keeps the flag set.
    always_comb begin
        ovr_d = ovr_q;
        if (lost_c) begin
            ovr_d = 1'b1;
        end else if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
    end

    // Idle timer counts oversample ticks while data sits untouched, saturating at the limit.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (fifo_clr_i | push_c | pop_c | empty_q) begin
            to_cnt_d = '0;
        end else if (tick_i && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        timeout_d = (to_cnt_d == TO_MAX);
    end

    // RTS next-state: hysteresis between the high and low watermarks on the upcoming count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RTS_READY: begin
                if (!rx_en_i || (count_d >= HW_CNT)) begin
                    state_d = RTS_HOLD;
                end
            end
            RTS_HOLD: begin
                if (rx_en_i && (count_d <= LW_CNT)) begin
                    state_d = RTS_READY;
                end
            end
            default: begin
                state_d = RTS_HOLD;
            end
        endcase
    end

    // State registers for FIFO control, flags, timer and flow control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            state_q   <= RTS_HOLD;
            rts_no_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovr_q     <= ovr_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            state_q   <= state_d;
            rts_no_q  <= (state_q == RTS_HOLD);
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata_c)
    );

    // Head entry falls through from storage; forced to zero when nothing is buffered.
    always_comb begin
        head_c = mem_rdata_c;
        if (empty_q) begin
            head_c = '0;
        end
    end

    assign rd_data_o       = head_c.data;
    assign rd_parity_err_o = head_c.parity_err;
    assign rd_stop_err_o   = head_c.stop_err;
    assign count_o         = count_q;
    assign empty_o         = empty_q;
    assign full_o          = full_q;
    assign overrun_o       = ovr_q;
    assign timeout_o       = timeout_q;
    assign rts_no          = rts_no_q;

endmodule : uart_rx_buffer_ctrl
